// File: rtl/zmips_dmem_pkg.sv
// zmips_dmem_pkg: MMIO offsets, status/fault bit positions and decode result type
package zmips_dmem_pkg;
  localparam logic [3:0] OFF_CON_TX   = 4'h0;
  localparam logic [3:0] OFF_CON_STAT = 4'h4;
  localparam logic [3:0] OFF_CYCLE    = 4'h8;
  localparam logic [3:0] OFF_FAULT    = 4'hC;
  localparam int STAT_FULL    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_OVF     = 2;
  localparam int STAT_CNT_LSB = 4;
  localparam int FLT_UNMAPPED = 0;
  localparam int FLT_MISALIGN = 1;
  typedef enum logic [1:0] {DEC_RAM, DEC_MMIO, DEC_UNMAPPED} dec_e;
endpackage

// File: rtl/zmips_con_fifo.sv
// zmips_con_fifo: byte FIFO for the console with a sticky overflow flag
module zmips_con_fifo #(
  parameter int DEPTH = 8,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push_i,
  input  logic [7:0]  data_i,
  input  logic        pop_i,
  output logic [7:0]  data_o,
  output logic        full_o,
  output logic        empty_o,
  output logic [AW:0] count_o,
  output logic        ovf_o
);
  logic [7:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q, cnt_d;
  logic ovf_q, do_push, do_pop;
  assign empty_o = cnt_q == '0;
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign do_pop = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign cnt_d = cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
  assign data_o = empty_o ? 8'h00 : mem_q[rd_q];
  assign count_o = cnt_q;
  assign ovf_o = ovf_q;
  always_ff @(posedge clk)
    if (!rst && do_push) mem_q[wr_q] <= data_i;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      wr_q  <= wr_q + AW'(do_push);
      rd_q  <= rd_q + AW'(do_pop);
      cnt_q <= cnt_d;
      ovf_q <= ovf_q | (push_i && !do_push);
    end
  end
endmodule

// File: rtl/zmips_dmem.sv
// zmips_dmem: data RAM plus console/cycle/fault MMIO; CYCLE register only when ZMIPS_DMEM_CYCLE_CNT_EN is defined
module zmips_dmem
  import zmips_dmem_pkg::*;
#(
  parameter int          DEPTH      = 4096,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000,
  localparam int         IW         = $clog2(DEPTH),
  localparam int         FW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_data_o,
  input  logic        d_wr,
  input  logic        d_rd,
  output logic [31:0] d_data_i,
  output logic [7:0]  con_data,
  output logic        con_valid,
  input  logic        con_ready,
  output logic        fault
);
  localparam logic [31:0] RAM_LIM = 32'(DEPTH * 4);
  logic [31:0] mem_q [DEPTH];
  logic [1:0] fault_q, fault_d, flt_set, flt_clr;
  logic [31:0] stat, cyc_rd, mmio_rd;
  logic [FW:0] fifo_cnt;
  logic [3:0] off;
  logic mis, acc, wr_ok, mmio_wr, push, full, empty, ovf;
  dec_e dec;
  assign dec = d_addr < RAM_LIM ? DEC_RAM :
               d_addr[31:4] == MMIO_BASE[31:4] ? DEC_MMIO : DEC_UNMAPPED;
  assign mis = d_addr[1:0] != 2'b00;
  assign acc = d_wr || d_rd;
  assign wr_ok = d_wr && !mis;
  assign off = {d_addr[3:2], 2'b00};
  assign mmio_wr = wr_ok && dec == DEC_MMIO;
  assign push = mmio_wr && off == OFF_CON_TX;
  always_ff @(posedge clk)
    if (!rst && wr_ok && dec == DEC_RAM) mem_q[d_addr[IW+1:2]] <= d_data_o;
  zmips_con_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (d_data_o[7:0]),
    .pop_i   (con_ready),
    .data_o  (con_data),
    .full_o  (full),
    .empty_o (empty),
    .count_o (fifo_cnt),
    .ovf_o   (ovf)
  );
  assign con_valid = !empty;
  always_comb begin
    stat = '0;
    stat[STAT_FULL] = full;
    stat[STAT_EMPTY] = empty;
    stat[STAT_OVF] = ovf;
    stat[STAT_CNT_LSB +: 4] = 4'(fifo_cnt);
  end
`ifdef ZMIPS_DMEM_CYCLE_CNT_EN
  logic [31:0] cyc_q;
  always_ff @(posedge clk)
    if (rst) cyc_q <= '0;
    else cyc_q <= (mmio_wr && off == OFF_CYCLE) ? d_data_o : cyc_q + 32'd1;
  assign cyc_rd = cyc_q;
`else
  assign cyc_rd = '0;
`endif
  always_comb begin
    flt_set = '0;
    flt_set[FLT_UNMAPPED] = acc && dec == DEC_UNMAPPED;
    flt_set[FLT_MISALIGN] = acc && mis;
  end
  // write-1-to-clear; a simultaneous new fault wins over the clear
  assign flt_clr = (mmio_wr && off == OFF_FAULT) ? d_data_o[1:0] : 2'b00;
  assign fault_d = (fault_q & ~flt_clr) | flt_set;
  always_ff @(posedge clk)
    if (rst) fault_q <= '0;
    else fault_q <= fault_d;
  assign fault = |fault_q || ovf;
  assign mmio_rd = off == OFF_CON_STAT ? stat :
                   off == OFF_CYCLE    ? cyc_rd :
                   off == OFF_FAULT    ? {30'd0, fault_q} : 32'd0;
  assign d_data_i = !d_rd ? 32'd0 :
                    dec == DEC_RAM  ? mem_q[d_addr[IW+1:2]] :
                    dec == DEC_MMIO ? mmio_rd : 32'd0;
endmodule
